fetch_ctrl: RTL

//  Instruction fetch/decode sequencer driving the PC block's control side: decodes the word returned by
//  the synchronous program ROM and issues jsr/ret/preload/relative_addr to the PC, one decision per cycle.

---
 rtl/fetch_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch/decode sequencer for the PC block.
// Boots the PC, decodes ROM words, tracks call depth.
module fetch_ctrl #(
  parameter logic [10:0] RESET_ADDR  = 11'd0,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [10:0] pc,
  input  logic [15:0] instr,
  output logic        jsr,
  output logic        ret,
  output logic        preload,
  output logic [10:0] preload_addr,
  output logic [9:0]  relative_addr,
  output logic        op_valid,
  output logic [3:0]  op_code,
  output logic [11:0] op_operand,
  input  logic        op_ready,
  output logic [2:0]  depth,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FILL,
    S_RUN,
    S_STALL,
    S_HALTED
  } state_t;

  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  state_t      state_q, state_d;
  logic [2:0]  depth_q, depth_d;
  logic        fault_q, fault_d;
  logic        ds_q, ds_d;
  logic [15:0] hold_q, hold_d;

  logic [3:0] opc;
  logic       is_nop, is_op, is_br;
  logic       is_jsr, is_ret, is_jmp, is_halt;
  logic       bad_slot;

  // Opcode classification of the word being decoded
  always_comb begin
    opc      = instr[15:12];
    is_nop   = (opc == 4'h0);
    is_br    = opc[3] & opc[2];
    is_op    = !is_nop && !is_br;
    is_jsr   = (opc == 4'hC);
    is_ret   = (opc == 4'hD);
    is_jmp   = (opc == 4'hE);
    is_halt  = (opc == 4'hF);
    bad_slot = ds_q && is_br;
  end

  // Next-state and control outputs
  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    fault_d       = fault_q;
    ds_d          = ds_q;
    hold_d        = hold_q;
    jsr           = 1'b0;
    ret           = 1'b0;
    preload       = 1'b0;
    preload_addr  = 11'd0;
    relative_addr = 10'd0;
    op_valid      = 1'b0;
    op_code       = 4'd0;
    op_operand    = 12'd0;
    unique case (state_q)
      S_BOOT: begin
        preload      = 1'b1;
        preload_addr = RESET_ADDR;
        state_d      = S_FILL;
      end
      S_FILL: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        unique case (1'b1)
          bad_slot: begin
            fault_d = 1'b1;
            state_d = S_HALTED;
          end
          is_nop: begin
            ds_d = 1'b0;
          end
          is_op: begin
            ds_d       = 1'b0;
            op_valid   = 1'b1;
            op_code    = instr[15:12];
            op_operand = instr[11:0];
            if (!op_ready) begin
              hold_d       = instr;
              preload      = 1'b1;
              preload_addr = pc;
              state_d      = S_STALL;
            end
          end
          is_jsr && !ds_q: begin
            if (depth_q == DEPTH_MAX) begin
              fault_d = 1'b1;
              state_d = S_HALTED;
            end else begin
              jsr           = 1'b1;
              relative_addr = instr[9:0];
              depth_d       = depth_q + 3'd1;
              ds_d          = 1'b1;
            end
          end
          is_ret && !ds_q: begin
            if (depth_q == 3'd0) begin
              fault_d = 1'b1;
              state_d = S_HALTED;
            end else begin
              ret     = 1'b1;
              depth_d = depth_q - 3'd1;
              ds_d    = 1'b1;
            end
          end
          is_jmp && !ds_q: begin
            preload      = 1'b1;
            preload_addr = instr[10:0];
            ds_d         = 1'b1;
          end
          is_halt && !ds_q: begin
            ds_d    = 1'b0;
            state_d = S_HALTED;
          end
        endcase
      end
      S_STALL: begin
        op_valid   = 1'b1;
        op_code    = hold_q[15:12];
        op_operand = hold_q[11:0];
        if (op_ready) begin
          state_d = S_RUN;
        end else begin
          preload      = 1'b1;
          preload_addr = pc;
        end
      end
      S_HALTED: begin
        preload      = 1'b1;
        preload_addr = pc;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BOOT;
      depth_q <= 3'd0;
      fault_q <= 1'b0;
      ds_q    <= 1'b0;
      hold_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
      ds_q    <= ds_d;
      hold_q  <= hold_d;
    end
  end

  assign depth  = depth_q;
  assign fault  = fault_q;
  assign halted = (state_q == S_HALTED);

endmodule
